// File: rtl/regbank_arb_pkg.sv
// Shared types and constants for the register-bank arbiter.
package regbank_arb_pkg;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;

  localparam int CPU_ID = 0;
  localparam int SPI_ID = 1;

endpackage

// File: rtl/regbank_arbiter_rr_arb2.sv
// Two-way round-robin pick: on a tie the requester not granted last wins.
module rr_arb2 (
  input  logic       last_grant,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  assign gnt[0] = req[0] & (~req[1] | last_grant);
  assign gnt[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/regbank_arbiter.sv
// Arbitrates CPU and SPI access onto one register-bank port, with optional
// bounded lock ownership and a one-cycle registered read response.
//
// state | meaning
// IDLE  | round-robin between both requesters
// OWN0  | CPU holds the bank under lock
// OWN1  | SPI holds the bank under lock
module regbank_arbiter
  import regbank_arb_pkg::*;
#(
  parameter int REG_WIDTH = 32,
  parameter int REG_COUNT = 16,
  parameter int LOCK_MAX  = 8,
  localparam int ADDR_W   = $clog2(REG_COUNT)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_we,
  input  logic [1:0]             req_lock,
  input  logic [2*ADDR_W-1:0]    req_addr,
  input  logic [2*REG_WIDTH-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [REG_WIDTH-1:0]   rsp_rdata,
  output logic                   rb_we,
  output logic [ADDR_W-1:0]      rb_waddr,
  output logic [REG_WIDTH-1:0]   rb_wdata,
  output logic [ADDR_W-1:0]      rb_raddr1,
  output logic [ADDR_W-1:0]      rb_raddr2,
  input  logic [REG_WIDTH-1:0]   rb_rdata1,
  input  logic [REG_WIDTH-1:0]   rb_rdata2
);

  localparam int LOCK_CW = $clog2(LOCK_MAX + 1);

  arb_state_t           state, state_d;
  logic                 last_grant, last_grant_d;
  logic [LOCK_CW-1:0]   lock_cnt, lock_cnt_d;
  logic [ADDR_W-1:0]    raddr_q;
  logic [1:0]           rr_gnt;
  logic [1:0]           ready_raw;
  logic [1:0]           xfer;
  logic                 sel;
  logic                 any_xfer;
  logic                 rd_xfer;
  logic                 own_id;
  logic [ADDR_W-1:0]    sel_addr;
  logic [REG_WIDTH-1:0] sel_wdata;
  logic                 unused_rdata2;

  rr_arb2 u_rr (
    .last_grant (last_grant),
    .req        (req_valid),
    .gnt        (rr_gnt)
  );

  always_comb begin
    ready_raw = 2'b00;
    case (state)
      IDLE:    ready_raw = rr_gnt;
      OWN0:    ready_raw = {1'b0, req_valid[CPU_ID]};
      OWN1:    ready_raw = {req_valid[SPI_ID], 1'b0};
      default: ready_raw = 2'b00;
    endcase
  end

  // Gated by rst_n so nothing reaches the bank while reset is held.
  assign req_ready = ready_raw & {2{rst_n}};
  assign xfer      = req_valid & req_ready;
  assign any_xfer  = |xfer;
  assign sel       = xfer[1];
  assign sel_addr  = sel ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
  assign sel_wdata = sel ? req_wdata[REG_WIDTH +: REG_WIDTH] : req_wdata[0 +: REG_WIDTH];
  assign rd_xfer   = any_xfer & ~req_we[sel];

  assign rb_we     = any_xfer & req_we[sel];
  assign rb_waddr  = rb_we ? sel_addr : '0;
  assign rb_wdata  = rb_we ? sel_wdata : '0;
  assign rb_raddr1 = rd_xfer ? sel_addr : raddr_q;
  assign rb_raddr2 = '0;

  assign unused_rdata2 = ^rb_rdata2;
  assign own_id        = (state == OWN1);

  always_comb begin
    state_d      = state;
    lock_cnt_d   = lock_cnt;
    last_grant_d = last_grant;
    if (any_xfer) last_grant_d = sel;
    case (state)
      IDLE: begin
        if (any_xfer && req_lock[sel]) begin
          state_d    = sel ? OWN1 : OWN0;
          lock_cnt_d = LOCK_CW'(1);
        end
      end
      OWN0, OWN1: begin
        if (!req_valid[own_id]) begin
          state_d    = IDLE;
          lock_cnt_d = '0;
        end else if (any_xfer) begin
          // Reaching LOCK_MAX-1 forces release; last_grant already points here.
          if (req_lock[own_id] && lock_cnt < LOCK_CW'(LOCK_MAX - 1)) begin
            lock_cnt_d = lock_cnt + LOCK_CW'(1);
          end else begin
            state_d    = IDLE;
            lock_cnt_d = '0;
          end
        end
      end
      default: begin
        state_d    = IDLE;
        lock_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      lock_cnt   <= '0;
      rsp_valid  <= 2'b00;
      rsp_rdata  <= '0;
      raddr_q    <= '0;
    end else begin
      state      <= state_d;
      last_grant <= last_grant_d;
      lock_cnt   <= lock_cnt_d;
      rsp_valid  <= rd_xfer ? (sel ? 2'b10 : 2'b01) : 2'b00;
      if (rd_xfer) rsp_rdata <= rb_rdata1;
      raddr_q    <= rb_raddr1;
    end
  end

endmodule

// File: tb/tb_regbank_arbiter.sv
// Directed bench for regbank_arbiter with a behavioural register bank.
module tb_regbank_arbiter;

  localparam int REG_WIDTH = 32;
  localparam int REG_COUNT = 16;
  localparam int LOCK_MAX  = 8;
  localparam int ADDR_W    = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           req_valid, req_ready, req_we, req_lock, rsp_valid;
  logic [ADDR_W-1:0]    a0, a1;
  logic [REG_WIDTH-1:0] w0, w1;
  logic [REG_WIDTH-1:0] rsp_rdata, rb_wdata, rb_rdata1, rb_rdata2;
  logic                 rb_we;
  logic [ADDR_W-1:0]    rb_waddr, rb_raddr1, rb_raddr2;
  logic [REG_WIDTH-1:0] mem [REG_COUNT];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  regbank_arbiter #(.REG_WIDTH(REG_WIDTH), .REG_COUNT(REG_COUNT), .LOCK_MAX(LOCK_MAX)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_lock  (req_lock),
    .req_addr  ({a1, a0}),
    .req_wdata ({w1, w0}),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rb_we     (rb_we),
    .rb_waddr  (rb_waddr),
    .rb_wdata  (rb_wdata),
    .rb_raddr1 (rb_raddr1),
    .rb_raddr2 (rb_raddr2),
    .rb_rdata1 (rb_rdata1),
    .rb_rdata2 (rb_rdata2)
  );

  initial for (int i = 0; i < REG_COUNT; i++) mem[i] = '0;
  always @(posedge clk) if (rb_we) mem[rb_waddr] <= rb_wdata;
  assign rb_rdata1 = mem[rb_raddr1];
  assign rb_rdata2 = 32'hA5A5_A5A5;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 2'b11; req_we = 2'b00; req_lock = 2'b00;
    a0 = 4'd2; a1 = 4'd4; w0 = '0; w1 = '0;
    #12;
    check_eq("rst_ready", req_ready, 2'b00);
    check_eq("rst_rb_we", rb_we, 1'b0);
    check_eq("rst_raddr", rb_raddr1, 4'd0);
    check_eq("rst_rsp_valid", rsp_valid, 2'b00);
    check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
    check_eq("raddr2_tied", rb_raddr2, 4'd0);
    tick();
    rst_n = 1'b1;
    #1;

    // Both valid, no lock: CPU wins the first tie, then strict alternation.
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("alt_ready_%0d", i), req_ready, (i % 2 == 0) ? 2'b01 : 2'b10);
      tick();
    end
    req_valid = 2'b00;
    #1;
    check_eq("idle_no_ready", req_ready, 2'b00);
    check_eq("idle_rb_we", rb_we, 1'b0);
    tick();

    // CPU write 3 then read 3.
    req_valid = 2'b01; req_we = 2'b01; a0 = 4'd3; w0 = 32'hDEADBEEF;
    #1;
    check_eq("cpu_wr_ready", req_ready, 2'b01);
    check_eq("cpu_wr_we", rb_we, 1'b1);
    check_eq("cpu_wr_addr", rb_waddr, 4'd3);
    check_eq("cpu_wr_data", rb_wdata, 32'hDEADBEEF);
    check_eq("wr_no_rsp_pending", rsp_valid, 2'b00);
    tick();
    check_eq("wr_no_rsp", rsp_valid, 2'b00);
    req_we = 2'b00;
    #1;
    check_eq("cpu_rd_we", rb_we, 1'b0);
    check_eq("cpu_rd_raddr", rb_raddr1, 4'd3);
    tick();
    check_eq("cpu_rsp_valid", rsp_valid, 2'b01);
    check_eq("cpu_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    req_valid = 2'b00; a0 = 4'd9;
    tick();
    check_eq("rsp_one_cycle", rsp_valid, 2'b00);
    check_eq("raddr_hold", rb_raddr1, 4'd3);

    // SPI locks for reads 1,2 and releases on read 3; CPU waits until the 4th.
    req_valid = 2'b11; a0 = 4'd0; a1 = 4'd1; req_lock = 2'b10;
    #1;
    check_eq("lk3_g1", req_ready, 2'b10);
    tick();
    check_eq("lk3_rsp1", rsp_valid, 2'b10);
    a1 = 4'd2;
    #1;
    check_eq("lk3_g2", req_ready, 2'b10);
    tick();
    a1 = 4'd3; req_lock = 2'b00;
    #1;
    check_eq("lk3_g3", req_ready, 2'b10);
    tick();
    check_eq("lk3_g4_cpu", req_ready, 2'b01);
    tick();

    // SPI holds lock continuously: exactly LOCK_MAX grants, then CPU.
    req_lock = 2'b10;
    #1;
    for (int i = 0; i < LOCK_MAX; i++) begin
      check_eq($sformatf("lk8_spi_%0d", i), req_ready, 2'b10);
      tick();
    end
    check_eq("lk8_cpu_after", req_ready, 2'b01);
    tick();
    req_valid = 2'b00; req_lock = 2'b00;
    tick();

    // SPI write 7 immediately followed by CPU read 7.
    req_valid = 2'b10; req_we = 2'b10; a1 = 4'd7; w1 = 32'h12345678;
    #1;
    check_eq("spi_wr_ready", req_ready, 2'b10);
    check_eq("spi_wr_addr", rb_waddr, 4'd7);
    check_eq("spi_wr_data", rb_wdata, 32'h12345678);
    tick();
    req_valid = 2'b01; req_we = 2'b00; a0 = 4'd7;
    #1;
    check_eq("raw_raddr", rb_raddr1, 4'd7);
    tick();
    check_eq("raw_rsp_valid", rsp_valid, 2'b01);
    check_eq("raw_rsp_rdata", rsp_rdata, 32'h12345678);

    // CPU read 5 with reset asserted before the capturing edge.
    a0 = 4'd5;
    #1;
    check_eq("mid_rd_ready", req_ready, 2'b01);
    #1 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_ready", req_ready, 2'b00);
    tick();
    check_eq("mid_rst_rsp", rsp_valid, 2'b00);
    rst_n = 1'b1; req_valid = 2'b11;
    #1;
    check_eq("post_rst_tie_cpu", req_ready, 2'b01);
    tick();
    check_eq("post_rst_rsp_cpu", rsp_valid, 2'b01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
